// File: rtl/aes_cbc_sequencer_if.sv
// Handshake and data bundle between the CBC sequencer, its environment and the AES decrypt core.
interface aes_cbc_sequencer_if #(
  parameter int unsigned NBW = 16
);
  logic             enable_i;
  logic             start_i;
  logic [NBW-1:0]   nblocks_i;
  logic [255:0]     key_i;
  logic [127:0]     iv_i;
  logic [127:0]     ct_i;
  logic             ct_valid_i;
  logic             ct_ready_o;
  logic [127:0]     pt_o;
  logic             pt_valid_o;
  logic             pt_ready_i;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [255:0]     core_k_o;
  logic             core_kvalid_o;
  logic [127:0]     core_iv_o;
  logic             core_ivalid_o;
  logic [127:0]     core_c_o;
  logic             core_cvalid_o;
  logic [127:0]     core_plain_i;
  logic             core_ready_i;
  logic             core_valid_i;

  modport slave (
    input  enable_i, start_i, nblocks_i, key_i, iv_i, ct_i, ct_valid_i, pt_ready_i,
           core_plain_i, core_ready_i, core_valid_i,
    output ct_ready_o, pt_o, pt_valid_o, busy_o, done_o, err_o,
           core_k_o, core_kvalid_o, core_iv_o, core_ivalid_o, core_c_o, core_cvalid_o
  );

  modport master (
    output enable_i, start_i, nblocks_i, key_i, iv_i, ct_i, ct_valid_i, pt_ready_i,
           core_plain_i, core_ready_i, core_valid_i,
    input  ct_ready_o, pt_o, pt_valid_o, busy_o, done_o, err_o,
           core_k_o, core_kvalid_o, core_iv_o, core_ivalid_o, core_c_o, core_cvalid_o
  );
endinterface

// File: rtl/aes_cbc_sequencer.sv
// CBC decrypt sequencer: loads key/IV once, streams ciphertext blocks through the core one at
// a time, chains each ciphertext as the next IV and buffers plaintext in a small FIFO.
module aes_cbc_sequencer #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned NBW     = 16
) (
  input logic               clk,
  input logic               resetn,
  aes_cbc_sequencer_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_RDY, S_ISSUE, S_WAIT_RES, S_CHAIN, S_DONE, S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic [255:0]    key_q, key_d;
  logic [127:0]    iv_q, iv_d;
  logic [127:0]    c_q, c_d;
  logic [127:0]    chain_q, chain_d;
  logic [NBW-1:0]  blk_q, blk_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic            err_q, err_d;
  logic            cvalid_q, cvalid_d;

  logic [127:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q;

  logic            ct_ready_c;
  logic            push_c;
  logic            pop_c;
  logic            timeout_c;

  // Only accept a block when the FIFO can still absorb its result.
  assign ct_ready_c = (state_q == S_ISSUE) && (cnt_q <= CW'(DEPTH - 1));
  assign timeout_c  = (wdog_q == WW'(TIMEOUT - 1));
  assign pop_c      = bus.enable_i && bus.pt_ready_i && (cnt_q != '0);

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    iv_d     = iv_q;
    c_d      = c_q;
    chain_d  = chain_q;
    blk_d    = blk_q;
    wdog_d   = wdog_q;
    err_d    = err_q;
    cvalid_d = 1'b0;
    push_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          key_d   = bus.key_i;
          iv_d    = bus.iv_i;
          blk_d   = bus.nblocks_i;
          err_d   = 1'b0;
          state_d = (bus.nblocks_i == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD:     state_d = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (bus.core_ready_i) begin
          state_d = S_ISSUE;
        end else if (timeout_c) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      S_ISSUE: begin
        if (bus.ct_valid_i && ct_ready_c) begin
          c_d      = bus.ct_i;
          chain_d  = bus.ct_i;
          cvalid_d = 1'b1;
          state_d  = S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        if (bus.core_valid_i) begin
          push_c  = 1'b1;
          blk_d   = blk_q - NBW'(1);
          iv_d    = chain_q;
          state_d = (blk_q == NBW'(1)) ? S_DONE : S_CHAIN;
        end else if (timeout_c) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      S_CHAIN:    state_d = S_WAIT_RDY;
      S_DONE:     state_d = S_IDLE;
      S_ERR:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Watchdog restarts on every state change and only runs while waiting on the core.
    if (state_d != state_q) begin
      wdog_d = '0;
    end else if ((state_q == S_WAIT_RDY) || (state_q == S_WAIT_RES)) begin
      wdog_d = wdog_q + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      key_q    <= '0;
      iv_q     <= '0;
      c_q      <= '0;
      chain_q  <= '0;
      blk_q    <= '0;
      wdog_q   <= '0;
      err_q    <= 1'b0;
      cvalid_q <= 1'b0;
    end else if (bus.enable_i) begin
      state_q  <= state_d;
      key_q    <= key_d;
      iv_q     <= iv_d;
      c_q      <= c_d;
      chain_q  <= chain_d;
      blk_q    <= blk_d;
      wdog_q   <= wdog_d;
      err_q    <= err_d;
      cvalid_q <= cvalid_d;
    end
  end

  // Plaintext FIFO; push only happens from WAIT_RES, so it is implicitly enable-gated.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (bus.enable_i) begin
      if (push_c) begin
        mem_q[wr_q] <= bus.core_plain_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_c) rd_q <= rd_q + AW'(1);
      if (push_c && !pop_c)      cnt_q <= cnt_q + CW'(1);
      else if (!push_c && pop_c) cnt_q <= cnt_q - CW'(1);
    end
  end

  assign bus.ct_ready_o    = bus.enable_i && ct_ready_c;
  assign bus.pt_o          = mem_q[rd_q];
  assign bus.pt_valid_o    = (cnt_q != '0);
  assign bus.busy_o        = (state_q != S_IDLE);
  assign bus.done_o        = bus.enable_i && (state_q == S_DONE);
  assign bus.err_o         = err_q;
  assign bus.core_k_o      = key_q;
  assign bus.core_kvalid_o = bus.enable_i && (state_q == S_LOAD);
  assign bus.core_iv_o     = iv_q;
  assign bus.core_ivalid_o = bus.enable_i && ((state_q == S_LOAD) || (state_q == S_CHAIN));
  assign bus.core_c_o      = c_q;
  assign bus.core_cvalid_o = bus.enable_i && cvalid_q;

endmodule
